// File: rtl/brick_health_writer_if.sv
// Bus bundle for brick_health_writer: level ROM port, hit handshake, draw request
// handshake and the level status outputs.
interface brick_health_writer_if #(
  parameter int IDX_W = 6,
  parameter int HP_W  = 2
);
  logic             start_level;
  logic [IDX_W-1:0] rom_addr;
  logic [HP_W-1:0]  rom_data;
  logic [9:0]       total_health;
  logic             load_done;
  logic             hit_valid;
  logic [IDX_W-1:0] hit_idx;
  logic             hit_ready;
  logic             game_write;
  logic             draw_req;
  logic [IDX_W-1:0] draw_idx;
  logic [HP_W-1:0]  draw_health;
  logic             draw_ack;

  modport master (
    input  start_level, rom_data, hit_valid, hit_idx, draw_ack,
    output rom_addr, total_health, load_done, hit_ready, game_write,
           draw_req, draw_idx, draw_health
  );

  modport slave (
    output start_level, rom_data, hit_valid, hit_idx, draw_ack,
    input  rom_addr, total_health, load_done, hit_ready, game_write,
           draw_req, draw_idx, draw_health
  );
endinterface

// File: rtl/brick_health_writer.sv
// Owns per-brick health: loads it from the level ROM, applies collision hits one
// at a time, pulses game_write per health unit removed and asks for a redraw.
module brick_health_writer #(
  parameter int NUM_BRICKS = 40,
  parameter int IDX_W      = 6,
  parameter int HP_W       = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  brick_health_writer_if.master bus
);
  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOAD_ADDR  = 3'd1;
  localparam logic [2:0] S_LOAD_WAIT  = 3'd2;
  localparam logic [2:0] S_READY      = 3'd3;
  localparam logic [2:0] S_HIT_UPDATE = 3'd4;
  localparam logic [2:0] S_DRAW_WAIT  = 3'd5;

  logic [2:0]                     state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [IDX_W-1:0]               hit_idx_q, hit_idx_d;
  logic [IDX_W-1:0]               draw_idx_q, draw_idx_d;
  logic [HP_W-1:0]                draw_health_q, draw_health_d;
  logic [9:0]                     total_q, total_d;
  logic                           load_done_q, load_done_d;
  logic                           draw_req_q, draw_req_d;
  logic [NUM_BRICKS-1:0][HP_W-1:0] health_q, health_d;

  logic [HP_W-1:0] cur_hp;
  logic [10:0]     total_sum;
  logic            last_idx, hit_in_range;

  // Health of the latched hit brick; hit_idx_q is always in range when used.
  always_comb begin
    cur_hp = '0;
    for (int i = 0; i < NUM_BRICKS; i++)
      if (hit_idx_q == IDX_W'(i)) cur_hp = health_q[i];
  end

  assign total_sum    = {1'b0, total_q} + {{(11-HP_W){1'b0}}, bus.rom_data};
  assign last_idx     = (idx_q == IDX_W'(NUM_BRICKS-1));
  assign hit_in_range = ({1'b0, bus.hit_idx} < (IDX_W+1)'(NUM_BRICKS));

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    hit_idx_d     = hit_idx_q;
    draw_idx_d    = draw_idx_q;
    draw_health_d = draw_health_q;
    total_d       = total_q;
    load_done_d   = load_done_q;
    draw_req_d    = draw_req_q;
    health_d      = health_q;
    case (state_q)
      S_LOAD_ADDR: state_d = S_LOAD_WAIT;
      S_LOAD_WAIT: begin
        for (int i = 0; i < NUM_BRICKS; i++)
          if (idx_q == IDX_W'(i)) health_d[i] = bus.rom_data;
        total_d = total_sum[10] ? 10'h3ff : total_sum[9:0];
        if (last_idx) begin
          state_d     = S_READY;
          load_done_d = 1'b1;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_LOAD_ADDR;
        end
      end
      S_READY: begin
        // Out-of-range hits are consumed here and never reach the health array.
        if (bus.hit_valid && hit_in_range) begin
          hit_idx_d = bus.hit_idx;
          state_d   = S_HIT_UPDATE;
        end
      end
      S_HIT_UPDATE: begin
        if (cur_hp == '0) begin
          state_d = S_READY;
        end else begin
          for (int i = 0; i < NUM_BRICKS; i++)
            if (hit_idx_q == IDX_W'(i)) health_d[i] = cur_hp - HP_W'(1);
          draw_req_d    = 1'b1;
          draw_idx_d    = hit_idx_q;
          draw_health_d = cur_hp - HP_W'(1);
          state_d       = S_DRAW_WAIT;
        end
      end
      S_DRAW_WAIT: begin
        if (bus.draw_ack) begin
          draw_req_d = 1'b0;
          state_d    = S_READY;
        end
      end
      default: state_d = state_q;
    endcase
    if (bus.start_level) begin
      state_d     = S_LOAD_ADDR;
      idx_d       = '0;
      total_d     = '0;
      load_done_d = 1'b0;
      draw_req_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      hit_idx_q     <= '0;
      draw_idx_q    <= '0;
      draw_health_q <= '0;
      total_q       <= '0;
      load_done_q   <= 1'b0;
      draw_req_q    <= 1'b0;
      health_q      <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      hit_idx_q     <= hit_idx_d;
      draw_idx_q    <= draw_idx_d;
      draw_health_q <= draw_health_d;
      total_q       <= total_d;
      load_done_q   <= load_done_d;
      draw_req_q    <= draw_req_d;
      health_q      <= health_d;
    end
  end

  assign bus.rom_addr     = idx_q;
  assign bus.total_health = total_q;
  assign bus.load_done    = load_done_q;
  assign bus.hit_ready    = (state_q == S_READY);
  assign bus.game_write   = (state_q == S_HIT_UPDATE) && (cur_hp != '0);
  assign bus.draw_req     = draw_req_q;
  assign bus.draw_idx     = draw_idx_q;
  assign bus.draw_health  = draw_health_q;
endmodule

// File: tb/tb_brick_health_writer.sv
// Directed bench for brick_health_writer: hit stimulus pushes expected game_write
// cycles and draw requests into queues that a negedge monitor pops and compares.
module tb_brick_health_writer;
  localparam int NB = 4;
  localparam int IW = 6;
  localparam int HW = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  brick_health_writer_if #(.IDX_W(IW), .HP_W(HW)) bus();
  brick_health_writer #(.NUM_BRICKS(NB), .IDX_W(IW), .HP_W(HW)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  typedef struct { int idx; int hp; } draw_t;

  int vectors = 0, miscompares = 0, cyc = 0, gw_cnt = 0;
  int ack_delay = 2;
  bit ack_en = 1'b1;
  logic [HW-1:0] rom [NB];
  draw_t exp_draw[$];
  int exp_gw[$];
  logic dr_prev = 1'b0;
  int hold_idx = 0, hold_hp = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr[1:0]];

  // Drawing FSM model: acks ack_delay cycles after draw_req is first seen.
  initial begin
    int cnt = 0;
    bus.draw_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.draw_ack) bus.draw_ack = 1'b0;
      else if (bus.draw_req && ack_en) begin
        if (cnt >= ack_delay) begin bus.draw_ack = 1'b1; cnt = 0; end
        else cnt++;
      end else cnt = 0;
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    draw_t e;
    if (bus.game_write) begin
      gw_cnt++;
      if (exp_gw.size() == 0) chk("unexpected_game_write", cyc, -1);
      else chk("game_write_cycle", cyc, exp_gw.pop_front());
    end
    if (bus.draw_req && !dr_prev) begin
      if (exp_draw.size() == 0) chk("unexpected_draw_req", int'(bus.draw_idx), -1);
      else begin
        e = exp_draw.pop_front();
        chk("draw_idx", int'(bus.draw_idx), e.idx);
        chk("draw_health", int'(bus.draw_health), e.hp);
      end
      hold_idx = int'(bus.draw_idx);
      hold_hp  = int'(bus.draw_health);
    end else if (bus.draw_req) begin
      chk("draw_idx_stable", int'(bus.draw_idx), hold_idx);
      chk("draw_health_stable", int'(bus.draw_health), hold_hp);
    end
    dr_prev = bus.draw_req;
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_rom_addr"}, int'(bus.rom_addr), 0);
    chk({tag, "_total"}, int'(bus.total_health), 0);
    chk({tag, "_load_done"}, int'(bus.load_done), 0);
    chk({tag, "_hit_ready"}, int'(bus.hit_ready), 0);
    chk({tag, "_game_write"}, int'(bus.game_write), 0);
    chk({tag, "_draw_req"}, int'(bus.draw_req), 0);
    chk({tag, "_draw_idx"}, int'(bus.draw_idx), 0);
    chk({tag, "_draw_health"}, int'(bus.draw_health), 0);
  endtask

  // Called on a negedge; returns on the negedge after the start_level edge + 2*NB.
  task automatic load(input int exp_total);
    bus.start_level = 1'b1;
    @(negedge clk);
    bus.start_level = 1'b0;
    chk("draw_req_dropped", int'(bus.draw_req), 0);
    for (int k = 0; k < 2*NB; k++) begin
      chk("rom_addr", int'(bus.rom_addr), k/2);
      chk("load_done_low", int'(bus.load_done), 0);
      chk("hit_ready_in_load", int'(bus.hit_ready), 0);
      @(negedge clk);
    end
    chk("load_done_rise", int'(bus.load_done), 1);
    chk("total_health", int'(bus.total_health), exp_total);
  endtask

  // Holds a hit until accepted; exp_wait = cycles hit_ready is seen low first.
  task automatic hit(input int idx, input bit dmg, input int hp_after, input int exp_wait);
    int w = 0;
    bus.hit_valid = 1'b1;
    bus.hit_idx   = IW'(idx);
    while (!bus.hit_ready && w < 60) begin w++; @(negedge clk); end
    if (!bus.hit_ready) begin
      chk("hit_accept_timeout", 0, 1);
      bus.hit_valid = 1'b0;
      return;
    end
    chk("hit_wait_cycles", w, exp_wait);
    if (dmg) begin
      exp_gw.push_back(cyc + 1);
      exp_draw.push_back('{idx, hp_after});
    end
    @(posedge clk);
    @(negedge clk);
    bus.hit_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (!bus.hit_ready && t < 60) begin t++; @(negedge clk); end
    chk("drain_ready", int'(bus.hit_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_level = 1'b0;
    bus.hit_valid   = 1'b0;
    bus.hit_idx     = '0;
    rom[0] = 2'd3; rom[1] = 2'd1; rom[2] = 2'd0; rom[3] = 2'd2;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    resetn = 1'b1;
    @(negedge clk);

    // Unloaded: hit must not be consumed
    bus.hit_valid = 1'b1;
    repeat (3) begin chk("hit_ready_unloaded", int'(bus.hit_ready), 0); @(negedge clk); end
    bus.hit_valid = 1'b0;

    load(6);
    ack_delay = 2;
    hit(1, 1, 0, 0);
    hit(1, 0, 0, 4);
    hit(0, 1, 2, 1);
    hit(0, 1, 1, 4);
    hit(0, 1, 0, 4);
    hit(0, 0, 0, 4);
    hit(5, 0, 0, 1);
    hit(2, 0, 0, 0);
    ack_delay = 10;
    hit(3, 1, 1, 1);
    hit(3, 1, 0, 12);
    hit(0, 0, 0, 12);
    drain();
    chk("game_write_count_level1", gw_cnt, 6);

    // start_level while a draw is pending
    ack_delay = 2;
    rom[0] = 2'd1; rom[1] = 2'd2; rom[2] = 2'd3; rom[3] = 2'd3;
    load(9);
    ack_en = 1'b0;
    hit(2, 1, 2, 0);
    repeat (3) @(negedge clk);
    chk("draw_req_held", int'(bus.draw_req), 1);
    rom[0] = 2'd2; rom[1] = 2'd0; rom[2] = 2'd1; rom[3] = 2'd0;
    load(3);
    ack_en = 1'b1;
    hit(2, 1, 0, 0);
    hit(1, 0, 0, 4);
    drain();

    // Asynchronous reset in the middle of a load
    rom[0] = 2'd3; rom[1] = 2'd1; rom[2] = 2'd0; rom[3] = 2'd2;
    bus.start_level = 1'b1;
    @(negedge clk);
    bus.start_level = 1'b0;
    repeat (3) @(negedge clk);
    #2 resetn = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge clk);
    resetn = 1'b1;
    bus.hit_valid = 1'b1;
    repeat (4) begin chk("hit_ready_after_reset", int'(bus.hit_ready), 0); @(negedge clk); end
    bus.hit_valid = 1'b0;
    load(6);
    hit(0, 1, 2, 0);
    drain();

    repeat (3) @(negedge clk);
    chk("exp_gw_left", exp_gw.size(), 0);
    chk("exp_draw_left", exp_draw.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/brick_health_writer.md
Name: brick_health_writer

Overview:
- Producer of per-hit damage events for the brick field; owns the health value of every brick.
- At level start, loads initial brick health from the level ROM and publishes the summed `total_health` for the win-detection logic.
- During play, accepts brick-hit requests from the ball collision logic and decrements the hit brick's health.
- For each accepted damaging hit, pulses `game_write` once and requests a redraw of that brick from the VGA drawing FSM.

Parameters:
- NUM_BRICKS, 40, number of bricks in the field (≥2).
- IDX_W, 6, brick index width; must satisfy 2^IDX_W ≥ NUM_BRICKS.
- HP_W, 2, per-brick health width (health 0..2^HP_W-1).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- start_level  in  1  one-cycle pulse; (re)starts the level load.
- rom_addr  out  IDX_W  level ROM address.
- rom_data  in  HP_W  level ROM data; valid exactly 1 cycle after rom_addr is presented.
- total_health  out  10  sum of all initial brick health.
- load_done  out  1  high while the level is loaded and the block is accepting hits.
- hit_valid  in  1  collision logic requests a hit on hit_idx.
- hit_idx  in  IDX_W  brick index of the hit.
- hit_ready  out  1  hit accepted on the cycle where hit_valid && hit_ready.
- game_write  out  1  one-cycle pulse per health unit removed.
- draw_req  out  1  redraw request to the drawing FSM.
- draw_idx  out  IDX_W  brick to redraw; stable while draw_req is high.
- draw_health  out  HP_W  new health of that brick (0 = erase); stable while draw_req is high.
- draw_ack  in  1  drawing FSM consumed the request.

Behaviour:
- Reset (async, resetn=0): state=IDLE_UNLOADED.
  - All outputs 0; total_health=0.
  - Health array cleared to 0.
- States: IDLE_UNLOADED, LOAD_ADDR, LOAD_WAIT, READY, HIT_UPDATE, DRAW_WAIT.
- start_level, accepted in any state, is the highest priority:
  - Go to LOAD_ADDR; internal index=0; total_health accumulator cleared to 0; load_done=0.
  - Any pending draw_req is dropped (draw_req=0 next cycle).
- Level load:
  - LOAD_ADDR: drive rom_addr=index; go to LOAD_WAIT.
  - LOAD_WAIT: store rom_data into health[index]; add it to total_health.
  - Accumulation saturates at 1023.
  - If index == NUM_BRICKS-1, go to READY and set load_done=1 the same cycle. Otherwise index+1 and return to LOAD_ADDR.
  - Full load takes 2*NUM_BRICKS cycles after start_level.
  - total_health is updated incrementally during the load and is final when load_done rises.
  - total_health holds its value until the next start_level or reset.
- hit_ready=1 only in READY.
- READY, on hit_valid:
  - Latch hit_idx; go to HIT_UPDATE.
  - If hit_idx ≥ NUM_BRICKS: hit is accepted and ignored (return to READY; no pulse, no draw).
- HIT_UPDATE (one cycle):
  - If health[idx]==0: no change, no game_write, return to READY.
  - Else: health[idx] -= 1 and game_write=1 for exactly this cycle.
  - Set draw_req=1, draw_idx=idx, draw_health=new value.
  - Go to DRAW_WAIT.
- DRAW_WAIT:
  - Hold draw_req and its fields until draw_ack=1.
  - On draw_ack, draw_req=0 next cycle; go to READY.
  - draw_ack outside DRAW_WAIT is ignored.
- Hit-to-game_write latency: game_write rises 1 cycle after the hit_valid && hit_ready cycle.
- At most one hit is in flight; further hits are back-pressured via hit_ready=0.
- Invariant: the total number of game_write pulses per level never exceeds total_health, when no saturation has occurred.
- Hit in IDLE_UNLOADED or during load: hit_ready=0; the request is not consumed.

Test Plan:
- Load with NUM_BRICKS=4, ROM={3,1,0,2} → load_done rises 8 cycles after start_level; total_health=6; rom_addr sequences 0,1,2,3.
- After load, hit idx 1 → game_write pulses once at hit+1; draw_req with draw_idx=1, draw_health=0; a second hit on idx 1 → no game_write, no draw_req.
- Hit idx 0 three times with draw_ack returned 2 cycles after each draw_req → three game_write pulses; draw_health = 2, 1, 0; hit_ready low from the accept until draw_ack+1.
- Hit asserted while draw_ack is withheld for 10 cycles → hit_ready stays 0; draw fields stable; hit consumed only after ack.
- start_level pulsed during DRAW_WAIT → draw_req drops next cycle; reload runs; total_health recomputed from the ROM; old health discarded.
- resetn asserted mid-load (async, no clock edge) → all outputs 0 immediately; hits not accepted until a new start_level completes.
